bsg_fifo_rolly_retx_ctrl: RTL and testbench

Go-back-N retransmit controller that sits directly downstream of the rollback FIFO's read side. It dequeues entries, tags each with a sequence number and sends them over a link with at most 2**lg_size_p frames outstanding. On a link ack it commits every dequeued entry in the FIFO. On a nack or timeout it rolls the FIFO read pointer back so the uncommitted window is resent.

---
 rtl/bsg_fifo_rolly_retx_pkg.sv | 24 ++
 rtl/bsg_fifo_rolly_retx_timer.sv | 43 ++++
 rtl/bsg_fifo_rolly_retx_ctrl.sv | 137 +++++++++++++
 tb/tb_bsg_fifo_rolly_retx_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/bsg_fifo_rolly_retx_pkg.sv
// bsg_fifo_rolly_retx_pkg: shared types and helpers for the go-back-N
// retransmit controller that drains a rollback FIFO onto a link.
package bsg_fifo_rolly_retx_pkg;

  // Controller phases: sending, committing an acked window, rewinding a
  // nacked/timed-out window, and the sticky retry-exhausted state.
  typedef enum logic [1:0] {
    SEND   = 2'd0,
    COMMIT = 2'd1,
    REWIND = 2'd2,
    ERROR  = 2'd3
  } retx_state_e;

  // Encoding of resp_ack_i.
  localparam logic RESP_ACK  = 1'b1;
  localparam logic RESP_NACK = 1'b0;

  // Sequence numbers carry one bit more than the window index so that a
  // full window and an empty window never share a base/next pair.
  function automatic int retx_seq_width(input int lg_size);
    return lg_size + 32'sd1;
  endfunction

endpackage

// File: rtl/bsg_fifo_rolly_retx_timer.sv
// bsg_fifo_rolly_retx_timer: response timeout counter for the retransmit
// controller. Only compiled when BSG_FIFO_ROLLY_RETX_TIMEOUT_EN is defined;
// without it the controller relies on nacks alone.
`ifdef BSG_FIFO_ROLLY_RETX_TIMEOUT_EN
module bsg_fifo_rolly_retx_timer #(
  parameter int timeout_p = 64
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic clear_i,
  input  logic en_i,
  input  logic active_i,
  output logic timeout_evt_o
);

  localparam logic [15:0] last_lp = 16'(timeout_p - 32'sd1);

  logic [15:0] cnt_q, cnt_d;

  // Clear has priority; otherwise count every enabled cycle.
  always_comb begin
    if (clear_i) begin
      cnt_d = 16'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_evt_o = active_i & (cnt_q == last_lp);

endmodule
`endif

// File: rtl/bsg_fifo_rolly_retx_ctrl.sv
// bsg_fifo_rolly_retx_ctrl: go-back-N retransmit controller. Dequeues the
// rollback FIFO, tags frames with a sequence number, commits the FIFO on
// ack and rewinds it on nack (or on timeout when
// BSG_FIFO_ROLLY_RETX_TIMEOUT_EN is defined).
module bsg_fifo_rolly_retx_ctrl
  import bsg_fifo_rolly_retx_pkg::*;
#(
  parameter int width_p       = 8,
  parameter int lg_size_p     = 2,
  parameter int timeout_p     = 64,
  parameter int max_retries_p = 3
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [width_p-1:0]             fifo_data_i,
  input  logic                           fifo_v_i,
  output logic                           fifo_yumi_o,
  output logic                           fifo_ack_v_o,
  output logic                           fifo_rollback_v_o,
  output logic [lg_size_p+width_p:0]     link_data_o,
  output logic                           link_v_o,
  input  logic                           link_ready_i,
  input  logic                           resp_v_i,
  input  logic                           resp_ack_i,
  output logic                           error_o
);

  localparam int seq_w_lp = retx_seq_width(lg_size_p);
  localparam logic [lg_size_p:0] window_lp   = {1'b1, {lg_size_p{1'b0}}};
  localparam logic [lg_size_p:0] cnt_one_lp  = {{lg_size_p{1'b0}}, 1'b1};
  localparam logic [seq_w_lp-1:0] seq_one_lp = {{(seq_w_lp-1){1'b0}}, 1'b1};
  localparam logic [7:0] max_retries_lp      = 8'(max_retries_p);

  typedef struct packed {
    logic [seq_w_lp-1:0] seq;
    logic [width_p-1:0]  payload;
  } frame_s;

  retx_state_e         state_q, state_d;
  logic [lg_size_p:0]  out_cnt_q, out_cnt_d;
  logic [seq_w_lp-1:0] seq_q, seq_d, seq_base_q, seq_base_d;
  logic [7:0]          retry_q, retry_d;

  logic   in_send_s, busy_s, resp_acc_s, ack_s, rewind_s;
  logic   link_v_s, xfer_s, timeout_evt_s;
  frame_s frame_out_s;

`ifdef BSG_FIFO_ROLLY_RETX_TIMEOUT_EN
  bsg_fifo_rolly_retx_timer #(
    .timeout_p(timeout_p)
  ) timer (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .clear_i      (xfer_s | resp_acc_s | rewind_s),
    .en_i         (in_send_s & busy_s),
    .active_i     (busy_s),
    .timeout_evt_o(timeout_evt_s)
  );
`else
  logic unused_timeout_s;
  assign timeout_evt_s    = 1'b0;
  assign unused_timeout_s = (timeout_p == 32'sd0);
`endif

  // Handshake decode: responses and timeouts pre-empt any send this cycle,
  // and the link is held quiet while reset is asserted.
  always_comb begin
    in_send_s   = (state_q == SEND);
    busy_s      = (out_cnt_q != {(lg_size_p+1){1'b0}});
    resp_acc_s  = in_send_s & resp_v_i & busy_s;
    ack_s       = resp_acc_s & (resp_ack_i == RESP_ACK);
    rewind_s    = (resp_acc_s & (resp_ack_i == RESP_NACK))
                | (in_send_s & timeout_evt_s & ~resp_acc_s);
    link_v_s    = reset_n_i & in_send_s & fifo_v_i & (out_cnt_q < window_lp)
                & ~resp_v_i & ~timeout_evt_s;
    xfer_s      = link_v_s & link_ready_i;
    frame_out_s = '{seq: seq_q, payload: fifo_data_i};
  end

  // Next-state and window bookkeeping.
  always_comb begin
    state_d    = state_q;
    out_cnt_d  = out_cnt_q;
    seq_d      = seq_q;
    seq_base_d = seq_base_q;
    retry_d    = retry_q;
    case (state_q)
      SEND: begin
        if (ack_s) begin
          state_d    = COMMIT;
          out_cnt_d  = {(lg_size_p+1){1'b0}};
          seq_base_d = seq_q;
          retry_d    = 8'd0;
        end else if (rewind_s) begin
          state_d   = REWIND;
          out_cnt_d = {(lg_size_p+1){1'b0}};
          seq_d     = seq_base_q;
          retry_d   = retry_q + 8'd1;
        end else if (xfer_s) begin
          out_cnt_d = out_cnt_q + cnt_one_lp;
          seq_d     = seq_q + seq_one_lp;
        end else begin
          state_d = SEND;
        end
      end
      COMMIT:  state_d = SEND;
      REWIND:  state_d = (retry_q == max_retries_lp) ? ERROR : SEND;
      ERROR:   state_d = ERROR;
      default: state_d = SEND;
    endcase
  end

  // Controller state registers; reset discards any in-flight window.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= SEND;
      out_cnt_q  <= {(lg_size_p+1){1'b0}};
      seq_q      <= {seq_w_lp{1'b0}};
      seq_base_q <= {seq_w_lp{1'b0}};
      retry_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      out_cnt_q  <= out_cnt_d;
      seq_q      <= seq_d;
      seq_base_q <= seq_base_d;
      retry_q    <= retry_d;
    end
  end

  assign fifo_yumi_o       = xfer_s;
  assign link_v_o          = link_v_s;
  assign link_data_o       = link_v_s ? frame_out_s : '0;
  assign fifo_ack_v_o      = (state_q == COMMIT);
  assign fifo_rollback_v_o = (state_q == REWIND);
  assign error_o           = (state_q == ERROR);

endmodule

// File: tb/tb_bsg_fifo_rolly_retx_ctrl.sv
// Randomized bench for bsg_fifo_rolly_retx_ctrl. The bench plays the
// rollback FIFO and the link; a pointer-level reference model predicts
// every output: entry k of the stream always travels with seq k mod 8.
module tb_bsg_fifo_rolly_retx_ctrl;

  localparam int W    = 8;
  localparam int LG   = 2;
  localparam int TMO  = 8;
  localparam int MAXR = 3;
  localparam int WIN  = 4;
  localparam int SEQM = 8;
`ifdef BSG_FIFO_ROLLY_RETX_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int P_SEND = 0, P_COMMIT = 1, P_REWIND = 2, P_ERROR = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [W-1:0]  fifo_data;
  logic          fifo_v, yumi, ack_v, rb_v, link_v, link_ready, resp_v, resp_ack, err;
  logic [LG+W:0] link_data;

  int checks = 0;
  int failures = 0;

  // Reference model (stream indices) and FIFO environment pointers.
  int phase, n, idle, retries, mrd, mcm;
  int frd, fcm, fwr;
  logic [W-1:0] mem [0:1023];

  always #5 clk = ~clk;

  bsg_fifo_rolly_retx_ctrl #(
    .width_p(W), .lg_size_p(LG), .timeout_p(TMO), .max_retries_p(MAXR)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .fifo_data_i(fifo_data), .fifo_v_i(fifo_v), .fifo_yumi_o(yumi),
    .fifo_ack_v_o(ack_v), .fifo_rollback_v_o(rb_v),
    .link_data_o(link_data), .link_v_o(link_v), .link_ready_i(link_ready),
    .resp_v_i(resp_v), .resp_ack_i(resp_ack), .error_o(err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    phase = P_SEND; n = 0; idle = 0; retries = 0; mrd = 0; mcm = 0;
    frd = 0; fcm = 0; fwr = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_link_v"}, link_v, 0);
    check_eq({tag, "_yumi"}, yumi, 0);
    check_eq({tag, "_ack_v"}, ack_v, 0);
    check_eq({tag, "_rollback_v"}, rb_v, 0);
    check_eq({tag, "_error"}, err, 0);
    check_eq({tag, "_link_data"}, link_data, 0);
  endtask

  // One clock: drive at negedge, compare at negedge+1, advance at posedge.
  task automatic cycle(input int p_ready, input int p_resp, input int p_ack);
    bit ra, tmo, ev, sy, sack, srb;
    logic [31:0] exp_frame;
    @(negedge clk);
    link_ready = ($urandom_range(99) < p_ready);
    resp_v     = ($urandom_range(99) < p_resp);
    resp_ack   = ($urandom_range(99) < p_ack);
    fifo_v     = (frd < fwr);
    fifo_data  = fifo_v ? mem[frd] : 8'h00;
    #1;
    ra  = (phase == P_SEND) && resp_v && (n > 0);
    tmo = TMO_EN && (phase == P_SEND) && (n > 0) && (idle == TMO - 1);
    ev  = (phase == P_SEND) && fifo_v && (n < WIN) && !resp_v && !tmo;
    check_eq("link_v", link_v, ev);
    check_eq("yumi", yumi, ev && link_ready);
    check_eq("ack_v", ack_v, phase == P_COMMIT);
    check_eq("rollback_v", rb_v, phase == P_REWIND);
    check_eq("error", err, phase == P_ERROR);
    if (ev) begin
      exp_frame = ((mrd % SEQM) << W) | mem[mrd];
      check_eq("frame", link_data, exp_frame);
    end
    sy = yumi; sack = ack_v; srb = rb_v;
    @(posedge clk);
    // FIFO environment follows the DUT's strobes.
    if (srb) frd = fcm;
    if (sack) fcm = frd;
    if (sy) frd++;
    if ((fwr - fcm) < WIN && $urandom_range(99) < 60) fwr++;
    // Reference model.
    if (phase == P_SEND) begin
      if (ra && resp_ack) begin
        mcm = mrd; n = 0; idle = 0; retries = 0; phase = P_COMMIT;
      end else if (ra || tmo) begin
        mrd = mcm; n = 0; idle = 0; retries++; phase = P_REWIND;
      end else if (ev && link_ready) begin
        mrd++; n++; idle = 0;
      end else if (n > 0) begin
        idle++;
      end
    end else if (phase == P_COMMIT) begin
      phase = P_SEND;
    end else if (phase == P_REWIND) begin
      phase = (retries == MAXR) ? P_ERROR : P_SEND;
    end
  endtask

  // Assert reset between clock edges and expect every output low at once.
  task automatic async_reset();
    @(negedge clk);
    fifo_v = 1'b1; fifo_data = 8'h5A; link_ready = 1'b1; resp_v = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(posedge clk);
    @(negedge clk);
    fifo_v = 1'b0;
    reset_n = 1'b1;
    model_reset();
  endtask

  int cfg [8][3] = '{
    '{100,  0, 100}, '{100, 15, 100}, '{ 60, 10,  50}, '{ 30, 20,   0},
    '{ 80,  5,  80}, '{ 50, 30,  70}, '{100,  3,  90}, '{ 70,  8,  20}
  };

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = W'($urandom);
    fifo_v = 1'b1; fifo_data = 8'hA5; link_ready = 1'b1;
    resp_v = 1'b0; resp_ack = 1'b0;
    model_reset();
    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    fifo_v = 1'b0;
    reset_n = 1'b1;
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 150; c++) cycle(cfg[s][0], cfg[s][1], cfg[s][2]);
      async_reset();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
